scene_sequencer: RTL and testbench
==================================

# scene_sequencer

Consumes the game-state outputs of the game logic (enemy positions, spawn flags, sprite addresses, base status, cursor, kill count) and turns them into a serialized stream of sprite draw jobs for the vector renderer. On each `frame_start` it snapshots all entity inputs, walks a fixed slot list, and issues one draw job per visible entity over a valid/ready request with a completion pulse. It sits between the game logic and the vector draw engine in the 100 MHz domain.

## Interface
- `OUT_WIDTH`, 8, coordinate width.
- `ADDRESSWIDTH`, 16, sprite ROM address width.
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse that starts a frame.
- `xenemyN`, `yenemyN` in OUT_WIDTH each (N = 1..3): enemy positions.
- `spawn_enemyN` in 1: enemy N is alive and visible.
- `adr_enemyN` in ADDRESSWIDTH: enemy N sprite start address.
- `baseN_nuked` in 1 (N = 1..3): base N is destroyed.
- `xcursor`, `ycursor` in OUT_WIDTH: cursor position.
- `killcount` in OUT_WIDTH: score.
- `draw_valid` out 1: draw job is pending.
- `draw_ready` in 1: the renderer accepts the job.
- `draw_x`, `draw_y` out OUT_WIDTH: job origin.
- `draw_adr` out ADDRESSWIDTH: job sprite start address.
- `draw_done` in 1: one-cycle pulse that marks the accepted sprite as fully drawn.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `frame_overrun` out 1: one-cycle pulse when `frame_start` arrives while `busy` is high.

## Operation
- Slot order:
  - 0–2: enemy1–3.
  - 3–5: base1–3.
  - 6: cursor.
  - 7–8: kill-count digits (only when the configuration macro is defined).
- Enemy slot: enabled only if its snapshotted `spawn_enemyN` = 1. Job is x/y/adr from the snapshot.
- Base slot: always enabled. Job is x = `X_BASEn`, y = `Y_BASEn`. Address is `ADR_BASE_NUKED` if nuked, else `ADR_BASE_OK`.
- Cursor slot: always enabled. Job is the snapshotted cursor position, address `ADR_CURSOR`.
- FSM states and transitions:
  - IDLE: on `frame_start`, snapshot all entity inputs, set slot to 0, go to SELECT.
  - SELECT: if the slot is enabled, load `draw_x`/`draw_y`/`draw_adr` and go to ISSUE. Otherwise advance the slot, or go to FINISH after the last slot.
  - ISSUE: `draw_valid` = 1 with job fields held stable. When `draw_valid & draw_ready`, go to WAIT_DONE.
  - WAIT_DONE: on `draw_done`, advance the slot and go to SELECT, or go to FINISH after the last slot.
  - FINISH: pulse `frame_done`, return to IDLE.
- Inputs that change mid-frame have no effect; only the snapshot is used.
- `frame_start` while busy: ignored, and `frame_overrun` pulses for 1 cycle.
- `draw_done` outside WAIT_DONE: ignored.
- `draw_ready` is don't-care when `draw_valid` = 0.
- Reset mid-frame: abandon the frame immediately and return to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, slot 0, snapshot cleared.
- All outputs are registered.
- Latency:
  - `frame_start` at cycle 0 gives `busy` = 1 and SELECT at cycle 1.
  - The first `draw_valid` is at cycle 2 if slot 0 is enabled.
- Each skipped slot costs exactly 1 cycle in SELECT.
- After a handshake at cycle t, `draw_valid` = 0 at t+1.
- `draw_done` at cycle t gives SELECT at t+1.
- `frame_done` pulses 1 cycle after the last `draw_done`, or 1 cycle after the last SELECT skip. `busy` drops in that same cycle.
- `frame_start` arriving in the FINISH cycle counts as overrun.

## Configuration
- Macro: `SCENE_KILLCOUNT_DRAW_EN`.
- Defined: slots 7/8 draw the upper and lower nibble of `killcount`.
  - Position: `X_KILL_DIGIT` (+ `DIGIT_PITCH` for slot 8), `Y_KILL_DIGIT`.
  - Address: `ADR_DIGIT_START + nibble*DIGIT_STRIDE`, truncated to ADDRESSWIDTH.
  - Both digit slots are always enabled.
- Undefined: the last slot is 6, and `killcount` is unused.

## Structure
- `img_pkg` holds `ADR_BASE_OK`, `ADR_BASE_NUKED`, `ADR_CURSOR`, `ADR_DIGIT_START`, `DIGIT_STRIDE`.
- `vector_pkg` holds `X_BASE1..3`, `Y_BASE1..3`, `X_KILL_DIGIT`, `Y_KILL_DIGIT`, `DIGIT_PITCH`, the slot-index typedef, and the FSM state enum.
- One sub-module, `scene_slot_mux`: combinational slot index plus snapshot in, enable/x/y/adr out.

## Test plan
- **All enemies alive, ready tied 1, done 1 cycle after acceptance:** jobs come out in order e1, e2, e3, b1, b2, b3, cursor, then `frame_done`. For enemy2 at (40, 100) with adr 0x0120, the second job is exactly (40, 100, 0x0120).
- **Only `spawn_enemy2` = 1, `base2_nuked` = 1:** the jobs are e2, b1 (`ADR_BASE_OK`), b2 (`ADR_BASE_NUKED`), b3, cursor. The first `draw_valid` appears at cycle 3.
- **Backpressure with `draw_ready` low for 5 cycles:** `draw_valid` and the job fields stay stable, and there is exactly one handshake per job.
- **Inputs change mid-frame:** change `xcursor` from 10 to 200 after the first handshake. The cursor job still carries x = 10.
- **`frame_start` while busy, with spurious `draw_done` in ISSUE:** `frame_overrun` pulses once, the frame still completes with no extra jobs, and the spurious `draw_done` is ignored.
- **Macro on, `killcount` = 0x2B:** slot 7 address is `ADR_DIGIT_START + 2*DIGIT_STRIDE`, slot 8 address is `ADR_DIGIT_START + 11*DIGIT_STRIDE`. Asserting `rst` during slot 8 gives all outputs 0 within 1 cycle.

Source files
------------

// File: rtl/img_pkg.sv
// Sprite ROM start addresses for fixed scene elements.
// Digit addresses are only used when SCENE_KILLCOUNT_DRAW_EN is defined.
package img_pkg;

    localparam int unsigned ADR_BASE_OK     = 32'h0000_0400;
    localparam int unsigned ADR_BASE_NUKED  = 32'h0000_0440;
    localparam int unsigned ADR_CURSOR      = 32'h0000_0480;
    localparam int unsigned ADR_DIGIT_START = 32'h0000_0500;
    localparam int unsigned DIGIT_STRIDE    = 32'h0000_0020;

endpackage

// File: rtl/vector_pkg.sv
// Screen layout, slot indexing and sequencer state encoding.
// SCENE_KILLCOUNT_DRAW_EN extends the slot list with two kill-count digits.
package vector_pkg;

    localparam int unsigned X_BASE1      = 32;
    localparam int unsigned Y_BASE1      = 220;
    localparam int unsigned X_BASE2      = 120;
    localparam int unsigned Y_BASE2      = 224;
    localparam int unsigned X_BASE3      = 208;
    localparam int unsigned Y_BASE3      = 220;
    localparam int unsigned X_KILL_DIGIT = 8;
    localparam int unsigned Y_KILL_DIGIT = 8;
    localparam int unsigned DIGIT_PITCH  = 12;

    typedef logic [3:0] slot_t;

    localparam slot_t SLOT_ENEMY1   = 4'd0;
    localparam slot_t SLOT_ENEMY2   = 4'd1;
    localparam slot_t SLOT_ENEMY3   = 4'd2;
    localparam slot_t SLOT_BASE1    = 4'd3;
    localparam slot_t SLOT_BASE2    = 4'd4;
    localparam slot_t SLOT_BASE3    = 4'd5;
    localparam slot_t SLOT_CURSOR   = 4'd6;
    localparam slot_t SLOT_DIGIT_HI = 4'd7;
    localparam slot_t SLOT_DIGIT_LO = 4'd8;

`ifdef SCENE_KILLCOUNT_DRAW_EN
    localparam slot_t LAST_SLOT = SLOT_DIGIT_LO;
`else
    localparam slot_t LAST_SLOT = SLOT_CURSOR;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISH    = 3'd4
    } state_t;

endpackage

// File: rtl/scene_slot_mux.sv
// Maps a slot index plus the frame snapshot to one draw job (enable, x, y, adr).
// With SCENE_KILLCOUNT_DRAW_EN, slots 7/8 draw the kill-count nibbles.
module scene_slot_mux
    import vector_pkg::*;
    import img_pkg::*;
#(
    parameter int OUT_WIDTH    = 8,
    parameter int ADDRESSWIDTH = 16
) (
    input  slot_t                          slot_i,
    input  logic [2:0]                     spawn_i,
    input  logic [2:0][OUT_WIDTH-1:0]      enemy_x_i,
    input  logic [2:0][OUT_WIDTH-1:0]      enemy_y_i,
    input  logic [2:0][ADDRESSWIDTH-1:0]   enemy_adr_i,
    input  logic [2:0]                     nuked_i,
    input  logic [OUT_WIDTH-1:0]           cursor_x_i,
    input  logic [OUT_WIDTH-1:0]           cursor_y_i,
`ifdef SCENE_KILLCOUNT_DRAW_EN
    input  logic [OUT_WIDTH-1:0]           killcount_i,
`endif
    output logic                           en_o,
    output logic [OUT_WIDTH-1:0]           x_o,
    output logic [OUT_WIDTH-1:0]           y_o,
    output logic [ADDRESSWIDTH-1:0]        adr_o
);

    function automatic logic [ADDRESSWIDTH-1:0] base_adr(input logic nuked);
        return nuked ? ADDRESSWIDTH'(ADR_BASE_NUKED) : ADDRESSWIDTH'(ADR_BASE_OK);
    endfunction

`ifdef SCENE_KILLCOUNT_DRAW_EN
    // Wraps silently if the digit table would run past the address space.
    function automatic logic [ADDRESSWIDTH-1:0] digit_adr(input logic [3:0] nib);
        return ADDRESSWIDTH'(ADR_DIGIT_START + nib * DIGIT_STRIDE);
    endfunction
`endif

    always_comb begin
        en_o  = 1'b0;
        x_o   = '0;
        y_o   = '0;
        adr_o = '0;
        case (slot_i)
            SLOT_ENEMY1: begin
                en_o  = spawn_i[0];
                x_o   = enemy_x_i[0];
                y_o   = enemy_y_i[0];
                adr_o = enemy_adr_i[0];
            end
            SLOT_ENEMY2: begin
                en_o  = spawn_i[1];
                x_o   = enemy_x_i[1];
                y_o   = enemy_y_i[1];
                adr_o = enemy_adr_i[1];
            end
            SLOT_ENEMY3: begin
                en_o  = spawn_i[2];
                x_o   = enemy_x_i[2];
                y_o   = enemy_y_i[2];
                adr_o = enemy_adr_i[2];
            end
            SLOT_BASE1: begin
                en_o  = 1'b1;
                x_o   = OUT_WIDTH'(X_BASE1);
                y_o   = OUT_WIDTH'(Y_BASE1);
                adr_o = base_adr(nuked_i[0]);
            end
            SLOT_BASE2: begin
                en_o  = 1'b1;
                x_o   = OUT_WIDTH'(X_BASE2);
                y_o   = OUT_WIDTH'(Y_BASE2);
                adr_o = base_adr(nuked_i[1]);
            end
            SLOT_BASE3: begin
                en_o  = 1'b1;
                x_o   = OUT_WIDTH'(X_BASE3);
                y_o   = OUT_WIDTH'(Y_BASE3);
                adr_o = base_adr(nuked_i[2]);
            end
            SLOT_CURSOR: begin
                en_o  = 1'b1;
                x_o   = cursor_x_i;
                y_o   = cursor_y_i;
                adr_o = ADDRESSWIDTH'(ADR_CURSOR);
            end
`ifdef SCENE_KILLCOUNT_DRAW_EN
            SLOT_DIGIT_HI: begin
                en_o  = 1'b1;
                x_o   = OUT_WIDTH'(X_KILL_DIGIT);
                y_o   = OUT_WIDTH'(Y_KILL_DIGIT);
                adr_o = digit_adr(killcount_i[7:4]);
            end
            SLOT_DIGIT_LO: begin
                en_o  = 1'b1;
                x_o   = OUT_WIDTH'(X_KILL_DIGIT + DIGIT_PITCH);
                y_o   = OUT_WIDTH'(Y_KILL_DIGIT);
                adr_o = digit_adr(killcount_i[3:0]);
            end
`endif
            default: begin
                en_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/scene_sequencer.sv
// Snapshots game state on frame_start and serialises one sprite draw job per
// visible slot to the vector renderer. SCENE_KILLCOUNT_DRAW_EN adds two digit slots.
module scene_sequencer
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH    = 8,
    parameter int ADDRESSWIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [OUT_WIDTH-1:0]    xenemy1,
    input  logic [OUT_WIDTH-1:0]    yenemy1,
    input  logic [OUT_WIDTH-1:0]    xenemy2,
    input  logic [OUT_WIDTH-1:0]    yenemy2,
    input  logic [OUT_WIDTH-1:0]    xenemy3,
    input  logic [OUT_WIDTH-1:0]    yenemy3,
    input  logic                    spawn_enemy1,
    input  logic                    spawn_enemy2,
    input  logic                    spawn_enemy3,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy1,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy2,
    input  logic [ADDRESSWIDTH-1:0] adr_enemy3,
    input  logic                    base1_nuked,
    input  logic                    base2_nuked,
    input  logic                    base3_nuked,
    input  logic [OUT_WIDTH-1:0]    xcursor,
    input  logic [OUT_WIDTH-1:0]    ycursor,
    input  logic [OUT_WIDTH-1:0]    killcount,
    output logic                    draw_valid,
    input  logic                    draw_ready,
    output logic [OUT_WIDTH-1:0]    draw_x,
    output logic [OUT_WIDTH-1:0]    draw_y,
    output logic [ADDRESSWIDTH-1:0] draw_adr,
    input  logic                    draw_done,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    frame_overrun
);

    // state        | meaning
    // ST_IDLE      | waiting for frame_start
    // ST_SELECT    | evaluate current slot: load job or skip
    // ST_ISSUE     | draw_valid high, waiting for draw_ready
    // ST_WAIT_DONE | job accepted, waiting for draw_done
    // ST_FINISH    | frame_done pulse cycle

    state_t                         state_q, state_d;
    slot_t                          slot_q, slot_d;
    logic                           draw_valid_q, draw_valid_d;
    logic [OUT_WIDTH-1:0]           draw_x_q, draw_x_d;
    logic [OUT_WIDTH-1:0]           draw_y_q, draw_y_d;
    logic [ADDRESSWIDTH-1:0]        draw_adr_q, draw_adr_d;
    logic                           busy_q, busy_d;
    logic                           frame_done_q, frame_done_d;
    logic                           frame_overrun_q, frame_overrun_d;
    logic                           snap_load;

    logic [2:0]                     snap_spawn_q;
    logic [2:0][OUT_WIDTH-1:0]      snap_ex_q;
    logic [2:0][OUT_WIDTH-1:0]      snap_ey_q;
    logic [2:0][ADDRESSWIDTH-1:0]   snap_eadr_q;
    logic [2:0]                     snap_nuked_q;
    logic [OUT_WIDTH-1:0]           snap_cx_q;
    logic [OUT_WIDTH-1:0]           snap_cy_q;
`ifdef SCENE_KILLCOUNT_DRAW_EN
    logic [OUT_WIDTH-1:0]           snap_kill_q;
`else
    logic                           unused_killcount;
    assign unused_killcount = ^killcount;
`endif

    logic                           slot_en;
    logic [OUT_WIDTH-1:0]           slot_x;
    logic [OUT_WIDTH-1:0]           slot_y;
    logic [ADDRESSWIDTH-1:0]        slot_adr;

    scene_slot_mux #(
        .OUT_WIDTH    (OUT_WIDTH),
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_slot_mux (
        .slot_i      (slot_q),
        .spawn_i     (snap_spawn_q),
        .enemy_x_i   (snap_ex_q),
        .enemy_y_i   (snap_ey_q),
        .enemy_adr_i (snap_eadr_q),
        .nuked_i     (snap_nuked_q),
        .cursor_x_i  (snap_cx_q),
        .cursor_y_i  (snap_cy_q),
`ifdef SCENE_KILLCOUNT_DRAW_EN
        .killcount_i (snap_kill_q),
`endif
        .en_o        (slot_en),
        .x_o         (slot_x),
        .y_o         (slot_y),
        .adr_o       (slot_adr)
    );

    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        draw_valid_d    = draw_valid_q;
        draw_x_d        = draw_x_q;
        draw_y_d        = draw_y_q;
        draw_adr_d      = draw_adr_q;
        busy_d          = busy_q;
        frame_done_d    = 1'b0;
        // Any frame_start outside IDLE (including FINISH) is dropped and flagged.
        frame_overrun_d = frame_start && (state_q != ST_IDLE);
        snap_load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    snap_load = 1'b1;
                    slot_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (slot_en) begin
                    draw_x_d     = slot_x;
                    draw_y_d     = slot_y;
                    draw_adr_d   = slot_adr;
                    draw_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (slot_q == LAST_SLOT) begin
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = ST_FINISH;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            ST_ISSUE: begin
                if (draw_valid_q && draw_ready) begin
                    draw_valid_d = 1'b0;
                    state_d      = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (draw_done) begin
                    if (slot_q == LAST_SLOT) begin
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = ST_FINISH;
                    end else begin
                        slot_d  = slot_q + 4'd1;
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            slot_q          <= '0;
            draw_valid_q    <= 1'b0;
            draw_x_q        <= '0;
            draw_y_q        <= '0;
            draw_adr_q      <= '0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            draw_valid_q    <= draw_valid_d;
            draw_x_q        <= draw_x_d;
            draw_y_q        <= draw_y_d;
            draw_adr_q      <= draw_adr_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            frame_overrun_q <= frame_overrun_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_spawn_q <= '0;
            snap_ex_q    <= '0;
            snap_ey_q    <= '0;
            snap_eadr_q  <= '0;
            snap_nuked_q <= '0;
            snap_cx_q    <= '0;
            snap_cy_q    <= '0;
`ifdef SCENE_KILLCOUNT_DRAW_EN
            snap_kill_q  <= '0;
`endif
        end else if (snap_load) begin
            snap_spawn_q <= {spawn_enemy3, spawn_enemy2, spawn_enemy1};
            snap_ex_q    <= {xenemy3, xenemy2, xenemy1};
            snap_ey_q    <= {yenemy3, yenemy2, yenemy1};
            snap_eadr_q  <= {adr_enemy3, adr_enemy2, adr_enemy1};
            snap_nuked_q <= {base3_nuked, base2_nuked, base1_nuked};
            snap_cx_q    <= xcursor;
            snap_cy_q    <= ycursor;
`ifdef SCENE_KILLCOUNT_DRAW_EN
            snap_kill_q  <= killcount;
`endif
        end
    end

    assign draw_valid    = draw_valid_q;
    assign draw_x        = draw_x_q;
    assign draw_y        = draw_y_q;
    assign draw_adr      = draw_adr_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: table of frame scenarios, expected
// jobs queued at frame_start and popped at each handshake.
module tb_scene_sequencer;

    localparam logic [15:0] A_BASE_OK    = 16'h0400;
    localparam logic [15:0] A_BASE_NUKED = 16'h0440;
    localparam logic [15:0] A_CURSOR     = 16'h0480;
    localparam logic [15:0] A_DIGIT      = 16'h0500;
    localparam logic [15:0] A_STRIDE     = 16'h0020;
    localparam logic [7:0]  XB1 = 8'd32,  YB1 = 8'd220;
    localparam logic [7:0]  XB2 = 8'd120, YB2 = 8'd224;
    localparam logic [7:0]  XB3 = 8'd208, YB3 = 8'd220;
    localparam logic [7:0]  XK  = 8'd8,   YK  = 8'd8, PITCH = 8'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [7:0]  xenemy1, yenemy1, xenemy2, yenemy2, xenemy3, yenemy3;
    logic        spawn_enemy1, spawn_enemy2, spawn_enemy3;
    logic [15:0] adr_enemy1, adr_enemy2, adr_enemy3;
    logic        base1_nuked, base2_nuked, base3_nuked;
    logic [7:0]  xcursor, ycursor, killcount;
    logic        draw_valid, draw_ready, draw_done;
    logic [7:0]  draw_x, draw_y;
    logic [15:0] draw_adr;
    logic        busy, frame_done, frame_overrun;

    scene_sequencer #(.OUT_WIDTH(8), .ADDRESSWIDTH(16)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .xenemy1(xenemy1), .yenemy1(yenemy1), .xenemy2(xenemy2), .yenemy2(yenemy2),
        .xenemy3(xenemy3), .yenemy3(yenemy3),
        .spawn_enemy1(spawn_enemy1), .spawn_enemy2(spawn_enemy2), .spawn_enemy3(spawn_enemy3),
        .adr_enemy1(adr_enemy1), .adr_enemy2(adr_enemy2), .adr_enemy3(adr_enemy3),
        .base1_nuked(base1_nuked), .base2_nuked(base2_nuked), .base3_nuked(base3_nuked),
        .xcursor(xcursor), .ycursor(ycursor), .killcount(killcount),
        .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_x(draw_x), .draw_y(draw_y), .draw_adr(draw_adr),
        .draw_done(draw_done), .busy(busy), .frame_done(frame_done),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] adr;
    } job_t;

    typedef struct {
        logic [2:0]       spawn;
        logic [2:0][7:0]  ex;
        logic [2:0][7:0]  ey;
        logic [2:0][15:0] eadr;
        logic [2:0]       nuked;
        logic [7:0]       cx, cy, kill;
        int               stall;
        bit               mid_change, ovr_poke, spurious, fin_poke;
        int               first_valid;
        int               n_jobs;
    } vec_t;

    job_t exp_q[$];
    vec_t vt[6];
    int   n_checks = 0;
    int   n_miss   = 0;
`ifdef SCENE_KILLCOUNT_DRAW_EN
    localparam int EXTRA_JOBS = 2;
`else
    localparam int EXTRA_JOBS = 0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] spawn, input logic [2:0] nuked,
                                input logic [7:0] cx, input logic [7:0] cy, input logic [7:0] kill,
                                input int stall, input bit mid, input bit ovr, input bit spur,
                                input bit fin, input int fv, input int nj);
        vec_t v;
        v.spawn = spawn;
        v.ex    = {8'd70, 8'd40, 8'd10};
        v.ey    = {8'd30, 8'd100, 8'd20};
        v.eadr  = {16'h0140, 16'h0120, 16'h0100};
        v.nuked = nuked;
        v.cx = cx; v.cy = cy; v.kill = kill;
        v.stall = stall; v.mid_change = mid; v.ovr_poke = ovr;
        v.spurious = spur; v.fin_poke = fin;
        v.first_valid = fv; v.n_jobs = nj;
        return v;
    endfunction

    task automatic apply_inputs(input vec_t v);
        xenemy1 = v.ex[0]; yenemy1 = v.ey[0]; adr_enemy1 = v.eadr[0];
        xenemy2 = v.ex[1]; yenemy2 = v.ey[1]; adr_enemy2 = v.eadr[1];
        xenemy3 = v.ex[2]; yenemy3 = v.ey[2]; adr_enemy3 = v.eadr[2];
        {spawn_enemy3, spawn_enemy2, spawn_enemy1} = v.spawn;
        {base3_nuked, base2_nuked, base1_nuked}    = v.nuked;
        xcursor = v.cx; ycursor = v.cy; killcount = v.kill;
    endtask

    task automatic push_expected(input vec_t v);
        for (int i = 0; i < 3; i++)
            if (v.spawn[i]) exp_q.push_back({v.ex[i], v.ey[i], v.eadr[i]});
        exp_q.push_back({XB1, YB1, v.nuked[0] ? A_BASE_NUKED : A_BASE_OK});
        exp_q.push_back({XB2, YB2, v.nuked[1] ? A_BASE_NUKED : A_BASE_OK});
        exp_q.push_back({XB3, YB3, v.nuked[2] ? A_BASE_NUKED : A_BASE_OK});
        exp_q.push_back({v.cx, v.cy, A_CURSOR});
`ifdef SCENE_KILLCOUNT_DRAW_EN
        exp_q.push_back({XK, YK, A_DIGIT + {12'd0, v.kill[7:4]} * A_STRIDE});
        exp_q.push_back({XK + PITCH, YK, A_DIGIT + {12'd0, v.kill[3:0]} * A_STRIDE});
`endif
    endtask

    task automatic run_frame(input vec_t v);
        int   first_valid, handshakes, ovr_pulses, stall_left, exp_jobs;
        bit   accepted_prev, stalled_prev, done_seen;
        job_t held, cur, expj;
        exp_jobs = v.n_jobs + EXTRA_JOBS;
        exp_q.delete();
        apply_inputs(v);
        @(negedge clk);
        frame_start = 1'b1;
        push_expected(v);
        first_valid = -1; handshakes = 0; ovr_pulses = 0; stall_left = v.stall;
        accepted_prev = 0; stalled_prev = 0; done_seen = 0; held = '0;
        for (int c = 1; c <= 300 && !done_seen; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            draw_done   = 1'b0;
            cur = {draw_x, draw_y, draw_adr};
            if (frame_overrun) ovr_pulses++;
            if (c == 1) check("busy_rise", busy, 1);
            if (v.ovr_poke && c == 3) frame_start = 1'b1;
            if (accepted_prev) begin
                check("valid_drop", draw_valid, 0);
                accepted_prev = 0;
                draw_done = 1'b1;
            end
            if (frame_done) begin
                done_seen = 1;
                check("busy_at_done", busy, 0);
                check("job_count", handshakes, exp_jobs);
                check("queue_empty", exp_q.size(), 0);
                if (v.fin_poke) frame_start = 1'b1;
            end else if (draw_valid) begin
                if (first_valid < 0) begin
                    first_valid = c;
                    check("first_valid_cycle", c, v.first_valid);
                end
                if (stalled_prev) check("hold_stable", cur, held);
                if (stall_left > 0) begin
                    draw_ready = 1'b0;
                    stall_left--;
                    held = cur;
                    stalled_prev = 1;
                    if (v.spurious) draw_done = 1'b1;
                end else begin
                    draw_ready = 1'b1;
                    stalled_prev = 0;
                    stall_left = v.stall;
                    accepted_prev = 1;
                    handshakes++;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_miss++;
                        $display("FAIL extra_job: got %0h, expected no job", cur);
                    end else begin
                        expj = exp_q.pop_front();
                        check("job", cur, expj);
                    end
                    if (v.mid_change && handshakes == 1) begin
                        xcursor = 8'd200; ycursor = 8'd1;
                        spawn_enemy2 = ~v.spawn[1];
                        adr_enemy3 = 16'hBEEF;
                        base2_nuked = ~v.nuked[1];
                        killcount = ~v.kill;
                    end
                end
            end else begin
                draw_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done_seen) begin
            n_checks++; n_miss++;
            $display("FAIL frame_timeout: got no frame_done, expected one within 300 cycles");
        end
        check("overrun_count", ovr_pulses, v.ovr_poke ? 1 : 0);
        @(negedge clk);
        frame_start = 1'b0;
        check("done_single_pulse", frame_done, 0);
        check("busy_after_done", busy, 0);
        if (v.fin_poke) begin
            check("finish_overrun", frame_overrun, 1);
            @(negedge clk);
            check("finish_start_ignored", {busy, draw_valid, frame_overrun}, 0);
        end
    endtask

    task automatic reset_mid_frame(input vec_t v, input int target_hs);
        int hs;
        bit acc_prev, reached;
        hs = 0; acc_prev = 0; reached = 0;
        exp_q.delete();
        apply_inputs(v);
        @(negedge clk);
        frame_start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            draw_done   = 1'b0;
            if (acc_prev) begin
                draw_done = 1'b1;
                acc_prev = 0;
            end else if (draw_valid) begin
                if (hs == target_hs) begin
                    reached = 1;
                    break;
                end
                draw_ready = 1'b1;
                hs++;
                acc_prev = 1;
            end
        end
        if (!reached) begin
            n_checks++; n_miss++;
            $display("FAIL reset_reach_timeout: got %0d handshakes, expected %0d", hs, target_hs);
        end
`ifdef SCENE_KILLCOUNT_DRAW_EN
        check("pending_slot8_adr", draw_adr, 16'h0660);
`else
        check("pending_cursor_adr", draw_adr, A_CURSOR);
`endif
        rst = 1'b1;
        #1;
        check("rst_outputs_async",
              {draw_valid, busy, frame_done, frame_overrun, draw_x, draw_y, draw_adr}, 0);
        @(negedge clk);
        rst = 1'b0;
        draw_done = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {busy, draw_valid, frame_done}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; draw_ready = 1'b0; draw_done = 1'b0;
        apply_inputs(mk(3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {draw_valid, busy, frame_done, frame_overrun, draw_x, draw_y, draw_adr}, 0);
        rst = 1'b0;
        @(negedge clk);

        //          spawn   nuked   cx      cy      kill   stl mid ovr spu fin fv nj
        vt[0] = mk(3'b111, 3'b000, 8'd10,  8'd50,  8'h2B, 0,  0,  0,  0,  0,  2, 7);
        vt[1] = mk(3'b010, 3'b010, 8'd90,  8'd90,  8'h00, 0,  0,  0,  0,  0,  3, 5);
        vt[2] = mk(3'b111, 3'b101, 8'd255, 8'd0,   8'hFF, 5,  0,  0,  0,  0,  2, 7);
        vt[3] = mk(3'b101, 3'b000, 8'd10,  8'd60,  8'h10, 0,  1,  0,  0,  0,  2, 6);
        vt[4] = mk(3'b000, 3'b111, 8'd0,   8'd255, 8'h09, 2,  0,  1,  1,  0,  5, 4);
        vt[5] = mk(3'b100, 3'b101, 8'd128, 8'd64,  8'hA5, 0,  0,  0,  0,  1,  4, 5);

        for (int i = 0; i < 6; i++) run_frame(vt[i]);

        reset_mid_frame(vt[0], vt[0].n_jobs + EXTRA_JOBS - 1);
        run_frame(vt[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
